// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding a single parallel-in/serial-out shifter, LSB-first.
// Grant in cycle T puts bit 0 on the wire at T+1; a new grant in the last-bit cycle chains frames gap-free.
module serial_tx_arbiter #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    serial_out,
  output logic                    frame,
  output logic [IDW-1:0]          grant_id
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    bitcnt_q;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   grant_id_q;

  logic             last_bit;
  logic             window;
  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;

  assign last_bit = (state_q == SHIFT) && (bitcnt_q == CW'(WIDTH - 1));
  assign window   = (state_q == IDLE) || last_bit;

  // Search starts one past the previous winner so every requester gets its turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && window && win_vld) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      grant_id_q   <= '0;
    end else if (|req_ready) begin
      state_q      <= SHIFT;
      shreg_q      <= req_data[int'(win_idx)*WIDTH +: WIDTH];
      bitcnt_q     <= '0;
      last_grant_q <= win_idx;
      grant_id_q   <= win_idx;
    end else if (state_q == SHIFT) begin
      shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
      if (last_bit) begin
        state_q  <= IDLE;
        bitcnt_q <= '0;
      end else begin
        bitcnt_q <= bitcnt_q + CW'(1);
      end
    end
  end

  assign frame      = (state_q == SHIFT);
  assign serial_out = frame & shreg_q[0];
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (WIDTH=4, NREQ=4) plus a randomized round-robin scoreboard.
module tb_serial_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        serial_out;
  logic        frame;
  logic [1:0]  grant_id;

  int checks;
  int errors;

  serial_tx_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .serial_out (serial_out),
    .frame      (frame),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Continuous handshake sanity, sampled mid-cycle.
  always @(negedge clk) begin
    chk("onehot", 32'($onehot0(req_ready)), 32'd1);
    if (reset) chk("rst_xfer", 32'(req_valid & req_ready), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  logic [3:0] bits;
  int         tbl[9] = '{1, 8, 1, 8, 1, 2, 8, 1, 2};

  // Random-phase reference model
  logic [3:0] m_word;
  logic [3:0] er;
  int         m_bit, m_last, m_id, g;
  bit         m_act, win;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_sout", 32'(serial_out), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_rdy", 32'(req_ready), 0);

    // Single request: requester 2, word 1011
    tick();
    req_valid = 4'b0100;
    req_data  = 16'h0B00;
    @(negedge clk);
    chk("s_rdy", 32'(req_ready), 32'b0100);
    bits = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("s_frame", 32'(frame), 1);
      chk("s_sout", 32'(serial_out), 32'(bits[k]));
      chk("s_gid", 32'(grant_id), 2);
    end
    tick();
    @(negedge clk);
    chk("s_end_frame", 32'(frame), 0);
    chk("s_end_sout", 32'(serial_out), 0);

    // All valid from reset, words 1,2,3,4
    do_reset();
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      chk("a_rdy", 32'(req_ready), (c % 4 == 0) ? (32'd1 << ((c / 4) % 4)) : 32'd0);
      if (c > 0) begin
        bits = 4'(((c - 1) / 4) % 4 + 1);
        chk("a_frame", 32'(frame), 1);
        chk("a_sout", 32'(serial_out), 32'(bits[(c - 1) % 4]));
        chk("a_gid", 32'(grant_id), 32'(((c - 1) / 4) % 4));
      end
    end

    // Fairness 0/3, then requester 1 joins mid-frame
    do_reset();
    req_valid = 4'b1001;
    req_data  = 16'h9075;
    for (int c = 0; c <= 32; c++) begin
      if (c > 0) tick();
      if (c == 13) req_valid[1] = 1'b1;
      @(negedge clk);
      chk("f_rdy", 32'(req_ready), (c % 4 == 0) ? 32'(tbl[c / 4]) : 32'd0);
    end

    // Mid-frame arrival and drop after transfer
    do_reset();
    req_valid = 4'b0001;
    req_data  = 16'h00A6;
    @(negedge clk);
    chk("m_rdy0", 32'(req_ready), 32'b0001);
    bits = 4'b0110;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        req_valid[0]   = 1'b0;
        req_data[3:0]  = 4'hF;
      end
      if (c == 2) req_valid[1] = 1'b1;
      @(negedge clk);
      chk("m_sout", 32'(serial_out), 32'(bits[c - 1]));
      chk("m_rdy", 32'(req_ready), (c == 4) ? 32'b0010 : 32'd0);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("m_gid1", 32'(grant_id), 1);
    chk("m_frame1", 32'(frame), 1);
    chk("m_sout1", 32'(serial_out), 0);

    // Reset during bit 2 of a frame
    do_reset();
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    @(negedge clk);
    chk("r_rdy0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    reset     = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("r_rdy_in_rst", 32'(req_ready), 0);
    tick();
    reset     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("r_frame", 32'(frame), 0);
    chk("r_sout", 32'(serial_out), 0);
    chk("r_rdy", 32'(req_ready), 0);
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("r_first", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("r_gid", 32'(grant_id), 0);
    chk("r_bit0", 32'(serial_out), 1);

    // Randomized traffic against a reference model
    do_reset();
    m_act  = 1'b0;
    m_bit  = 0;
    m_last = 3;
    m_id   = 0;
    m_word = '0;
    er     = '0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) tick();
      for (int i = 0; i < 4; i++) begin
        if (er[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*4 +: 4]   = 4'($urandom_range(0, 15));
        end
      end
      @(negedge clk);
      chk("q_frame", 32'(frame), 32'(m_act));
      chk("q_sout", 32'(serial_out), m_act ? 32'(m_word[m_bit]) : 32'd0);
      if (m_act) chk("q_gid", 32'(grant_id), 32'(m_id));
      win = !m_act || (m_bit == 3);
      er  = '0;
      g   = 0;
      if (win) begin
        for (int k = 1; k <= 4; k++) begin
          if (er == 0 && req_valid[(m_last + k) % 4]) begin
            g     = (m_last + k) % 4;
            er[g] = 1'b1;
          end
        end
      end
      chk("q_rdy", 32'(req_ready), 32'(er));
      if (er != 0) begin
        m_act  = 1'b1;
        m_bit  = 0;
        m_last = g;
        m_id   = g;
        m_word = req_data[g*4 +: 4];
      end else if (m_act) begin
        if (m_bit == 3) m_act = 1'b0;
        else m_bit++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Round-robin scheduler that shares one parallel-in/serial-out shifter between several requesters. Each requester offers a WIDTH-bit word with a valid/ready handshake. The block grants one requester at a time, loads its word, and shifts it out LSB-first while a frame strobe is high. It sits between word-producing logic and a single-wire serial link. Back-to-back frames are produced with no idle gap.

## Interface
- WIDTH, 4, bits per word / frame length in cycles (≥2)
- NREQ, 4, number of requesters (≥2)
- IDW, $clog2(NREQ), width of grant_id (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset, sampled on posedge clk
- req_valid  input  NREQ  bit i: requester i has a word pending
- req_data  input  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]; must be stable while req_valid[i]=1 and req_ready[i]=0
- req_ready  output  NREQ  one-hot grant; a transfer occurs in a cycle where req_valid[i] & req_ready[i]
- serial_out  output  1  current serial bit
- frame  output  1  high while serial_out carries a valid bit
- grant_id  output  IDW  index of the requester whose word is being shifted

## Operation
- Two states: IDLE and SHIFT. Internal regs: shreg[WIDTH-1:0], bitcnt (0..WIDTH-1), last_grant (IDW bits).
- Arbitration window: any cycle in IDLE, or the SHIFT cycle with bitcnt==WIDTH-1 (the last bit).
- In the window, the winner is the first i with req_valid[i]=1, searching last_grant+1, last_grant+2, … modulo NREQ.
- req_ready is combinational from state, bitcnt, req_valid and last_grant. At most one bit is high, and only inside the window. req_ready never depends on req_data.
- On a grant to i at the clock edge:
  - shreg <= req_data word i
  - bitcnt <= 0
  - last_grant <= i
  - grant_id <= i
  - state <= SHIFT
- SHIFT without a grant:
  - serial_out = shreg[0]
  - each edge: shreg <= {1'b0, shreg[WIDTH-1:1]}, bitcnt <= bitcnt+1
  - at bitcnt==WIDTH-1 with no valid request: state <= IDLE
- frame = (state==SHIFT). serial_out is 0 whenever frame=0.
- The pointer advances only on a grant. Requesters that are not valid are skipped.
- Deasserting req_valid[i] after its transfer has no effect; the word is already captured.
- Raising req_valid mid-frame is legal. The request waits for the last-bit cycle of the current frame.
- Reset, synchronous and taking priority over everything, including mid-frame. After the edge:
  - state=IDLE, shreg=0, bitcnt=0
  - last_grant=NREQ-1, so requester 0 has top priority first
  - grant_id=0, serial_out=0, frame=0, req_ready=0
  - A partially shifted word is discarded. No grant occurs in the cycle reset is high.

## Timing
- Grant (transfer) in cycle T means:
  - frame is high in cycles T+1 .. T+WIDTH
  - serial_out carries word bit k in cycle T+1+k
  - grant_id is valid from T+1
- Latency from valid to first bit:
  - 1 cycle when IDLE
  - otherwise up to WIDTH cycles plus round-robin wait
- Back-to-back: a grant in the last-bit cycle T+WIDTH gives the next frame's bit 0 at T+WIDTH+1. frame stays high continuously.
- Throughput: one WIDTH-bit word per WIDTH cycles under continuous demand.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once per NREQ frames.

## Test plan
- **Single request:** after reset, req_valid=4'b0100 with word 4'b1011 in cycle T.
  - req_ready=4'b0100 in T; grant_id=2.
  - serial_out = 1,1,0,1 in T+1..T+4, with frame high.
  - frame=0 and serial_out=0 at T+5.
- **All valid from reset:** all requesters continuously valid with words 1,2,3,4.
  - Grants occur in order 0,1,2,3,0 at cycles T, T+4, T+8, T+12, T+16.
  - frame has no gap; the serial stream is LSB-first of each word.
- **Fairness:**
  - req_valid[0] and req_valid[3] held high: grants alternate 0,3,0,3.
  - req_valid[1] raised mid-frame: next order is 1 at the following window if the pointer is past 0, else per round-robin. Check against a reference model.
- **Mid-frame arrival and drop:**
  - Requester 1 raises valid during bit 1 of requester 0's frame: req_ready[1] rises only in the last-bit cycle.
  - Requester 0 drops valid after its transfer: its frame still completes intact.
- **Reset mid-frame:** assert reset during bit 2 of a frame.
  - Next cycle: frame=0, serial_out=0, req_ready=0.
  - After release, with all valid, requester 0 is granted first.
- **Handshake stability:** check that req_ready is never multi-hot.
  - Check that no transfer occurs while reset is high.
  - Randomized valid patterns with a scoreboard confirm every accepted word is shifted exactly once.
